// File: rtl/led_pwm_pkg.sv
// Shared definitions for the LED PWM path:
// breath sequencer states and PWM sizing defaults.
package led_pwm_pkg;

  localparam int DEF_COUNTER_WIDTH = 8;
  localparam int DEF_MAX_COUNT = 200;

  typedef enum logic [2:0] {
    IDLE,
    RAMP_UP,
    HOLD_TOP,
    RAMP_DOWN,
    HOLD_BOTTOM
  } breathState_t;

endpackage

// File: rtl/pwm_period_counter.sv
// Counts PWM period pulses during a hold and
// flags the pulse that completes the hold.
module pwm_period_counter #(
  parameter int HOLD_PERIODS = 2
) (
  input  logic clk,
  input  logic rstN,
  input  logic clear,
  input  logic count,
  output logic termCount
);

  localparam int CW = (HOLD_PERIODS > 1) ? $clog2(HOLD_PERIODS) : 1;
  localparam logic [CW-1:0] LAST = CW'(HOLD_PERIODS - 1);

  logic [CW-1:0] cnt;

  assign termCount = count && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (!rstN || clear || termCount) begin
      cnt <= '0;
    end else if (count) begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/led_breath_sequencer.sv
// Triangular breathing duty ramp with holds at both
// extremes; duty only moves on PWM period boundaries.
module led_breath_sequencer
  import led_pwm_pkg::*;
#(
  parameter int COUNTER_WIDTH = DEF_COUNTER_WIDTH,
  parameter int MAX_COUNT = DEF_MAX_COUNT,
  parameter int STEP = 1,
  parameter int HOLD_PERIODS = 2
) (
  input  logic                     clk_in,
  input  logic                     rst_n_in,
  input  logic                     enable_in,
  input  logic                     period_end_in,
  output logic [COUNTER_WIDTH-1:0] duty_out,
  output logic                     duty_valid_out,
  output logic                     dir_out
);

  localparam int W = COUNTER_WIDTH;
  localparam logic [W:0] STEP_X = (W+1)'(STEP);
  localparam logic [W:0] MAX_X = (W+1)'(MAX_COUNT);
  localparam logic [W-1:0] STEP_N = W'(STEP);
  localparam logic [W-1:0] MAX_N = W'(MAX_COUNT);

  breathState_t state, stateNext;
  logic [W-1:0] dutyNext;
  logic         validNext;
  logic         dirNext;
  logic [W:0]   sum;
  logic         inHold;
  logic         holdDone;

  assign inHold = (state == HOLD_TOP) || (state == HOLD_BOTTOM);

  pwm_period_counter #(
    .HOLD_PERIODS(HOLD_PERIODS)
  ) uHold (
    .clk      (clk_in),
    .rstN     (rst_n_in),
    .clear    (!enable_in),
    .count    (period_end_in && enable_in && inHold),
    .termCount(holdDone)
  );

  always_comb begin
    stateNext = state;
    dutyNext  = duty_out;
    validNext = 1'b0;
    sum       = {1'b0, duty_out} + STEP_X;
    if (!enable_in) begin
      stateNext = IDLE;
      dutyNext  = '0;
      validNext = (duty_out != '0);
    end else begin
      unique case (state)
        IDLE: stateNext = RAMP_UP;
        RAMP_UP: begin
          if (period_end_in) begin
            validNext = 1'b1;
            if (sum >= MAX_X) begin
              dutyNext  = MAX_N;
              stateNext = HOLD_TOP;
              validNext = (duty_out != MAX_N);
            end else begin
              dutyNext = sum[W-1:0];
            end
          end
        end
        HOLD_TOP: if (holdDone) stateNext = RAMP_DOWN;
        RAMP_DOWN: begin
          if (period_end_in) begin
            validNext = 1'b1;
            if ({1'b0, duty_out} <= STEP_X) begin
              dutyNext  = '0;
              stateNext = HOLD_BOTTOM;
              validNext = (duty_out != '0);
            end else begin
              dutyNext = duty_out - STEP_N;
            end
          end
        end
        HOLD_BOTTOM: if (holdDone) stateNext = RAMP_UP;
        default: stateNext = IDLE;
      endcase
    end
    dirNext = (stateNext == RAMP_UP) || (stateNext == HOLD_TOP);
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      state          <= IDLE;
      duty_out       <= '0;
      duty_valid_out <= 1'b0;
      dir_out        <= 1'b0;
    end else begin
      state          <= stateNext;
      duty_out       <= dutyNext;
      duty_valid_out <= validNext;
      dir_out        <= dirNext;
    end
  end

endmodule

// File: tb/tb_led_breath_sequencer.sv
// Directed bench for led_breath_sequencer with three
// parameterisations sharing one stimulus stream.
module tb_led_breath_sequencer;

  logic clk = 1'b0;
  logic rstN;
  logic en;
  logic pe;

  logic [7:0] dutyA, dutyB, dutyC;
  logic validA, validB, validC;
  logic dirA, dirB, dirC;

  int asserts = 0;
  int fails = 0;

  typedef struct {
    int duty;
    bit valid;
    bit dir;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  led_breath_sequencer #(
    .COUNTER_WIDTH(8), .MAX_COUNT(200),
    .STEP(50), .HOLD_PERIODS(2)
  ) dutA (
    .clk_in(clk), .rst_n_in(rstN),
    .enable_in(en), .period_end_in(pe),
    .duty_out(dutyA), .duty_valid_out(validA),
    .dir_out(dirA)
  );

  led_breath_sequencer #(
    .COUNTER_WIDTH(8), .MAX_COUNT(200),
    .STEP(60), .HOLD_PERIODS(2)
  ) dutB (
    .clk_in(clk), .rst_n_in(rstN),
    .enable_in(en), .period_end_in(pe),
    .duty_out(dutyB), .duty_valid_out(validB),
    .dir_out(dirB)
  );

  led_breath_sequencer #(
    .COUNTER_WIDTH(8), .MAX_COUNT(5),
    .STEP(1), .HOLD_PERIODS(2)
  ) dutC (
    .clk_in(clk), .rst_n_in(rstN),
    .enable_in(en), .period_end_in(pe),
    .duty_out(dutyC), .duty_valid_out(validC),
    .dir_out(dirC)
  );

  task automatic step(input int which, input bit p,
                      input int d, input bit v, input bit r,
                      input string tag);
    exp_t e;
    logic [7:0] od;
    logic ov, odr;
    pe = p;
    sb.push_back('{duty: d, valid: v, dir: r});
    @(posedge clk);
    #1;
    pe = 1'b0;
    e = sb.pop_front();
    case (which)
      0: begin od = dutyA; ov = validA; odr = dirA; end
      1: begin od = dutyB; ov = validB; odr = dirB; end
      default: begin od = dutyC; ov = validC; odr = dirC; end
    endcase
    asserts++;
    assert (od === 8'(e.duty) && ov === e.valid && odr === e.dir)
    else begin
      fails++;
      $error("FAIL %s: observed duty=%0d valid=%0b dir=%0b, expected duty=%0d valid=%0b dir=%0b",
             tag, od, ov, odr, e.duty, e.valid, e.dir);
    end
  endtask

  task automatic runSeq(input int which, input int dq[$],
                        input bit rq[$], input bit gap,
                        input int startDuty, input string tag);
    int prev = startDuty;
    for (int i = 0; i < dq.size(); i++) begin
      step(which, 1'b1, dq[i], dq[i] != prev, rq[i],
           $sformatf("%s[%0d]", tag, i));
      if (gap)
        step(which, 1'b0, dq[i], 1'b0, rq[i],
             $sformatf("%s_hold[%0d]", tag, i));
      prev = dq[i];
    end
  endtask

  initial begin
    int dq[$];
    bit rq[$];
    rstN = 1'b0;
    en = 1'b0;
    pe = 1'b0;
    @(posedge clk);
    #1;
    step(0, 1'b0, 0, 1'b0, 1'b0, "reset");
    rstN = 1'b1;
    step(0, 1'b0, 0, 1'b0, 1'b0, "idleAfterReset");
    en = 1'b1;
    step(0, 1'b0, 0, 1'b0, 1'b1, "enableA");

    dq = '{50, 100, 150, 200, 200, 200, 150, 100, 50, 0, 0, 0, 50};
    rq = '{1, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 1, 1};
    runSeq(0, dq, rq, 1'b1, 0, "fullA");

    step(0, 1'b1, 100, 1'b1, 1'b1, "preReset");
    rstN = 1'b0;
    step(0, 1'b1, 0, 1'b0, 1'b0, "midRst0");
    step(0, 1'b0, 0, 1'b0, 1'b0, "midRst1");
    step(0, 1'b1, 0, 1'b0, 1'b0, "midRst2");
    rstN = 1'b1;
    step(0, 1'b0, 0, 1'b0, 1'b1, "rstRelease");

    dq = '{50, 100, 150};
    rq = '{1, 1, 1};
    runSeq(0, dq, rq, 1'b1, 0, "rampA");
    en = 1'b0;
    step(0, 1'b1, 0, 1'b1, 1'b0, "disableWithPe");
    step(0, 1'b0, 0, 1'b0, 1'b0, "disabledIdle");
    for (int i = 0; i < 3; i++)
      step(0, 1'b1, 0, 1'b0, 1'b0, $sformatf("peDisabled[%0d]", i));
    en = 1'b1;
    step(0, 1'b0, 0, 1'b0, 1'b1, "reEnable");
    step(0, 1'b1, 50, 1'b1, 1'b1, "restartFromZero");

    rstN = 1'b0;
    en = 1'b0;
    step(1, 1'b0, 0, 1'b0, 1'b0, "resetB");
    rstN = 1'b1;
    en = 1'b1;
    step(1, 1'b0, 0, 1'b0, 1'b1, "enableB");
    dq = '{60, 120, 180, 200, 200, 200, 140, 80, 20, 0};
    rq = '{1, 1, 1, 1, 1, 0, 0, 0, 0, 0};
    runSeq(1, dq, rq, 1'b0, 0, "satB");

    rstN = 1'b0;
    en = 1'b0;
    step(2, 1'b0, 0, 1'b0, 1'b0, "resetC");
    rstN = 1'b1;
    en = 1'b1;
    step(2, 1'b0, 0, 1'b0, 1'b1, "enableC");
    dq = '{1, 2, 3, 4, 5, 5, 5, 4, 3, 2,
           1, 0, 0, 0, 1, 2, 3, 4, 5, 5};
    rq = '{1, 1, 1, 1, 1, 1, 0, 0, 0, 0,
           0, 0, 0, 1, 1, 1, 1, 1, 1, 1};
    runSeq(2, dq, rq, 1'b0, 0, "b2bC");
    step(2, 1'b0, 5, 1'b0, 1'b1, "b2bCsettle");

    $display("End of test - %0d assertions evaluated, %0d failures",
             asserts, fails);
    $finish;
  end

endmodule
